// File: rtl/aes_block_streamer.sv
// aes_block_streamer: moves 128-bit blocks from a read FIFO through an AES core into a write FIFO
module aes_block_streamer #(
    parameter int DATA_W   = 16,
    parameter int NBLK_W   = 16,
    parameter int WR_DEPTH = 512,
    parameter int TMO_W    = 8
) (
    input  logic              iCLK,
    input  logic              iRST_n,
    input  logic              iSTART,
    input  logic [1:0]        iMODE,
    input  logic [NBLK_W-1:0] iNBLK,
    input  logic              iABORT,
    input  logic [15:0]       iRD_USEDW,
    output logic              oREAD,
    input  logic [DATA_W-1:0] iREADDATA,
    input  logic [15:0]       iWR_USEDW,
    output logic              oWRITE,
    output logic [DATA_W-1:0] oWRITEDATA,
    output logic              oAES_LD,
    output logic              oAES_KLD,
    output logic [127:0]      oAES_TEXT,
    input  logic              iAES_DONE,
    input  logic [127:0]      iAES_TEXT,
    output logic              oBUSY,
    output logic [1:0]        oDONE,
    output logic              oERR,
    output logic [NBLK_W-1:0] oBLK_CNT,
    output logic [3:0]        oSTATE
);
    localparam int WPB = 128 / DATA_W;
    localparam logic [1:0] ENC = 2'b10;
    localparam logic [1:0] DEC = 2'b01;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        KEYLD    = 4'd1,
        FILL     = 4'd2,
        READ     = 4'd3,
        LOAD     = 4'd4,
        WAIT_AES = 4'd5,
        DRAIN    = 4'd6,
        WRITE    = 4'd7,
        FIN      = 4'd8
    } state_t;

    state_t            state, state_nxt;
    logic [4:0]        wcnt, wcnt_nxt;
    logic [TMO_W-1:0]  tcnt, tcnt_nxt;
    logic [1:0]        mode_q, done_val;
    logic [NBLK_W-1:0] nblk_q, cnt_inc;
    logic [127:0]      blk_q, blk_nxt, res_q;
    logic [3:0]        cidx;
    logic [DATA_W-1:0] wd_nxt;
    logic              rd_nxt, wr_nxt, ld_nxt, kld_nxt;
    logic              start_ok, err_set, done_set, blk_inc, cap, res_ld;

    // during READ, wcnt=k+1 is the cycle in which word k arrives
    assign cidx    = wcnt[3:0] - 4'd1;
    assign cnt_inc = oBLK_CNT + 1'b1;
    assign oSTATE  = state;

    // Block being assembled with the arriving word dropped into its slot
    always_comb begin
        blk_nxt = blk_q;
        blk_nxt[(int'(cidx) % WPB)*DATA_W +: DATA_W] = iREADDATA;
    end

    // Next state, next strobes and status updates; abort overrides all of it last
    always_comb begin
        state_nxt = state;
        wcnt_nxt  = wcnt;
        tcnt_nxt  = tcnt;
        rd_nxt    = 1'b0;
        wr_nxt    = 1'b0;
        ld_nxt    = 1'b0;
        kld_nxt   = 1'b0;
        start_ok  = 1'b0;
        err_set   = 1'b0;
        done_set  = 1'b0;
        blk_inc   = 1'b0;
        cap       = 1'b0;
        res_ld    = 1'b0;
        done_val  = mode_q;
        case (state)
            IDLE, FIN: begin
                if (iSTART) begin
                    start_ok = 1'b1;
                    done_val = iMODE;
                    if (iMODE != ENC && iMODE != DEC) begin
                        state_nxt = FIN;
                        err_set   = 1'b1;
                    end else if (iNBLK == '0) begin
                        state_nxt = FIN;
                        done_set  = 1'b1;
                    end else if (iMODE == DEC) begin
                        state_nxt = KEYLD;
                        kld_nxt   = 1'b1;
                        wcnt_nxt  = '0;
                    end else begin
                        state_nxt = FILL;
                    end
                end
            end
            KEYLD: begin
                wcnt_nxt = wcnt + 5'd1;
                if (wcnt == 5'd16) state_nxt = FILL;
            end
            FILL: begin
                if (iRD_USEDW >= 16'(WPB)) begin
                    state_nxt = READ;
                    wcnt_nxt  = '0;
                    rd_nxt    = 1'b1;
                end
            end
            READ: begin
                wcnt_nxt = wcnt + 5'd1;
                rd_nxt   = wcnt_nxt < 5'(WPB);
                cap      = wcnt != '0;
                if (wcnt == 5'(WPB)) begin
                    state_nxt = LOAD;
                    ld_nxt    = 1'b1;
                end
            end
            LOAD: begin
                state_nxt = WAIT_AES;
                tcnt_nxt  = '0;
            end
            WAIT_AES: begin
                tcnt_nxt = tcnt + 1'b1;
                if (iAES_DONE) begin
                    state_nxt = DRAIN;
                    res_ld    = 1'b1;
                end else if (&tcnt_nxt) begin
                    state_nxt = FIN;
                    err_set   = 1'b1;
                end
            end
            DRAIN: begin
                if (iWR_USEDW <= 16'(WR_DEPTH - WPB)) begin
                    state_nxt = WRITE;
                    wcnt_nxt  = '0;
                    wr_nxt    = 1'b1;
                end
            end
            WRITE: begin
                wcnt_nxt = wcnt + 5'd1;
                wr_nxt   = wcnt_nxt < 5'(WPB);
                if (wcnt == 5'(WPB - 1)) begin
                    blk_inc = 1'b1;
                    if (cnt_inc == nblk_q) begin
                        state_nxt = FIN;
                        done_set  = 1'b1;
                    end else begin
                        state_nxt = FILL;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (iABORT) begin
            state_nxt = IDLE;
            rd_nxt    = 1'b0;
            wr_nxt    = 1'b0;
            ld_nxt    = 1'b0;
            kld_nxt   = 1'b0;
            start_ok  = 1'b0;
            err_set   = 1'b0;
            done_set  = 1'b0;
            blk_inc   = 1'b0;
            cap       = 1'b0;
            res_ld    = 1'b0;
        end
        wd_nxt = res_q[(int'(wcnt_nxt[3:0]) % WPB)*DATA_W +: DATA_W];
    end

    // State register
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) state <= IDLE;
        else         state <= state_nxt;
    end

    // Counters, registered strobes, block/result data and sticky status
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            wcnt       <= '0;
            tcnt       <= '0;
            mode_q     <= '0;
            nblk_q     <= '0;
            blk_q      <= '0;
            res_q      <= '0;
            oREAD      <= 1'b0;
            oWRITE     <= 1'b0;
            oWRITEDATA <= '0;
            oAES_LD    <= 1'b0;
            oAES_KLD   <= 1'b0;
            oAES_TEXT  <= '0;
            oBUSY      <= 1'b0;
            oDONE      <= '0;
            oERR       <= 1'b0;
            oBLK_CNT   <= '0;
        end else begin
            wcnt     <= wcnt_nxt;
            tcnt     <= tcnt_nxt;
            oREAD    <= rd_nxt;
            oWRITE   <= wr_nxt;
            oAES_LD  <= ld_nxt;
            oAES_KLD <= kld_nxt;
            oBUSY    <= state_nxt != IDLE;
            if (start_ok) begin
                mode_q   <= iMODE;
                nblk_q   <= iNBLK;
                oDONE    <= '0;
                oERR     <= 1'b0;
                oBLK_CNT <= '0;
            end
            if (err_set)  oERR       <= 1'b1;
            if (done_set) oDONE      <= done_val;
            if (blk_inc)  oBLK_CNT   <= cnt_inc;
            if (cap)      blk_q      <= blk_nxt;
            if (ld_nxt)   oAES_TEXT  <= blk_nxt;
            if (res_ld)   res_q      <= iAES_TEXT;
            if (wr_nxt)   oWRITEDATA <= wd_nxt;
        end
    end
endmodule
